// File: rtl/bp_cce_dir_rd_collect.sv
// Coherence-directory read-out: streams one way-group, tag-compares each entry, and folds the results into per-LCE hit/way/state vectors.
// Optional: define BP_CCE_DIR_RD_MULTIHIT_CHK_EN to flag a second valid match within one LCE on the sticky multihit_o.
module bp_cce_dir_rd_collect #(
  parameter int num_lce_p         = 2,
  parameter int lce_assoc_p       = 8,
  parameter int tag_width_p       = 20,
  parameter int entries_per_row_p = 4,
  parameter int way_group_width_p = 6,
  localparam int entry_w_lp        = tag_width_p + 3,
  localparam int rows_lp           = num_lce_p * lce_assoc_p / entries_per_row_p,
  localparam int lg_rows_lp        = (rows_lp > 1) ? $clog2(rows_lp) : 1,
  localparam int lce_assoc_width_p = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1
) (
  input  logic                                        clk_i,
  input  logic                                        reset_n_i,
  input  logic                                        cmd_v_i,
  output logic                                        cmd_ready_o,
  input  logic [way_group_width_p-1:0]                cmd_way_group_i,
  input  logic [tag_width_p-1:0]                      cmd_tag_i,
  output logic                                        ram_v_o,
  output logic [way_group_width_p+lg_rows_lp-1:0]     ram_addr_o,
  input  logic [entries_per_row_p*entry_w_lp-1:0]     ram_data_i,
  output logic                                        sharers_v_o,
  input  logic                                        sharers_yumi_i,
  output logic [num_lce_p-1:0]                        sharers_hits_o,
  output logic [num_lce_p*lce_assoc_width_p-1:0]      sharers_ways_o,
  output logic [num_lce_p*3-1:0]                      sharers_coh_states_o,
  output logic                                        multihit_o
);

  localparam int rows_per_lce_lp = lce_assoc_p / entries_per_row_p;
  localparam logic [2:0] coh_i_lp = 3'd0;

  typedef enum logic [1:0] {e_idle, e_read, e_drain, e_done} state_e;

  state_e                                state_q, state_d;
  logic [lg_rows_lp-1:0]                 row_q, row_d;
  logic [lg_rows_lp-1:0]                 proc_row_q;
  logic                                  rd_v_q;
  logic [way_group_width_p-1:0]          wg_q, wg_d;
  logic [tag_width_p-1:0]                tag_q, tag_d;
  logic [num_lce_p-1:0]                  hits_q, hits_d;
  logic [num_lce_p*lce_assoc_width_p-1:0] ways_q, ways_d;
  logic [num_lce_p*3-1:0]                states_q, states_d;
  logic                                  accept;

`ifdef BP_CCE_DIR_RD_MULTIHIT_CHK_EN
  logic multihit_q, multihit_d;
  assign multihit_o = multihit_q;
`else
  assign multihit_o = 1'b0;
`endif

  assign accept = cmd_ready_o & cmd_v_i;

  // NOTE: sequential state uses <= so every flop samples pre-edge values; comb blocks use = for in-order evaluation.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q    <= e_idle;
      row_q      <= '0;
      proc_row_q <= '0;
      rd_v_q     <= 1'b0;
      wg_q       <= '0;
      tag_q      <= '0;
      hits_q     <= '0;
      ways_q     <= '0;
      states_q   <= '0;
`ifdef BP_CCE_DIR_RD_MULTIHIT_CHK_EN
      multihit_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      proc_row_q <= row_q;
      rd_v_q     <= ram_v_o;
      wg_q       <= wg_d;
      tag_q      <= tag_d;
      hits_q     <= hits_d;
      ways_q     <= ways_d;
      states_q   <= states_d;
`ifdef BP_CCE_DIR_RD_MULTIHIT_CHK_EN
      multihit_q <= multihit_d;
`endif
    end
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    wg_d    = wg_q;
    tag_d   = tag_q;
    unique case (state_q)
      e_idle: if (accept) begin
        state_d = e_read;
        row_d   = '0;
        wg_d    = cmd_way_group_i;
        tag_d   = cmd_tag_i;
      end
      e_read: begin
        row_d = row_q + 1'b1;
        if (row_q == lg_rows_lp'(rows_lp - 1)) begin
          state_d = e_drain;
          row_d   = '0;
        end
      end
      e_drain: state_d = e_done;
      e_done:  if (sharers_yumi_i) state_d = e_idle;
      default: state_d = e_idle;
    endcase
  end

  // Outputs are forced low while reset is held so nothing leaks before the first reset edge.
  always_comb begin
    cmd_ready_o = 1'b0;
    ram_v_o     = 1'b0;
    sharers_v_o = 1'b0;
    if (reset_n_i) begin
      cmd_ready_o = (state_q == e_idle);
      ram_v_o     = (state_q == e_read);
      sharers_v_o = (state_q == e_done);
    end
  end

  assign ram_addr_o = {wg_q, row_q};

  // Each returning row belongs to one LCE; the first valid match (lowest way) wins.
  always_comb begin : row_merge
    int lce;
    int base;
    hits_d   = hits_q;
    ways_d   = ways_q;
    states_d = states_q;
`ifdef BP_CCE_DIR_RD_MULTIHIT_CHK_EN
    multihit_d = multihit_q;
`endif
    lce  = int'(proc_row_q) / rows_per_lce_lp;
    base = (int'(proc_row_q) % rows_per_lce_lp) * entries_per_row_p;
    if (accept) begin
      hits_d   = '0;
      ways_d   = '0;
      states_d = '0;
    end else if (rd_v_q) begin
      for (int j = 0; j < entries_per_row_p; j++) begin
        if ((ram_data_i[j*entry_w_lp +: tag_width_p] == tag_q) &&
            (ram_data_i[j*entry_w_lp+tag_width_p +: 3] != coh_i_lp)) begin
          if (!hits_d[lce]) begin
            hits_d[lce]                                      = 1'b1;
            ways_d[lce*lce_assoc_width_p +: lce_assoc_width_p] = lce_assoc_width_p'(base + j);
            states_d[lce*3 +: 3]                             = ram_data_i[j*entry_w_lp+tag_width_p +: 3];
          end
`ifdef BP_CCE_DIR_RD_MULTIHIT_CHK_EN
          else begin
            multihit_d = 1'b1;
          end
`endif
        end
      end
    end
  end

  assign sharers_hits_o       = hits_q;
  assign sharers_ways_o       = ways_q;
  assign sharers_coh_states_o = states_q;

endmodule

// File: tb/tb_bp_cce_dir_rd_collect.sv
// Directed bench for bp_cce_dir_rd_collect (2 LCEs, 8 ways, 4 entries per row => 4 rows per way-group).
module tb_bp_cce_dir_rd_collect;

  localparam logic [2:0] coh_i = 3'd0, coh_s = 3'd1, coh_e = 3'd2, coh_m = 3'd6;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        cmd_v_i = 1'b0;
  logic        cmd_ready_o;
  logic [5:0]  cmd_way_group_i = '0;
  logic [19:0] cmd_tag_i = '0;
  logic        ram_v_o;
  logic [7:0]  ram_addr_o;
  logic [91:0] ram_data_i;
  logic        sharers_v_o;
  logic        sharers_yumi_i = 1'b0;
  logic [1:0]  sharers_hits_o;
  logic [5:0]  sharers_ways_o;
  logic [5:0]  sharers_coh_states_o;
  logic        multihit_o;

  logic [91:0] dir_mem [256];
  int checks = 0;
  int failures = 0;

`ifdef BP_CCE_DIR_RD_MULTIHIT_CHK_EN
  localparam logic exp_multihit = 1'b1;
`else
  localparam logic exp_multihit = 1'b0;
`endif

  bp_cce_dir_rd_collect dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o),
    .cmd_way_group_i(cmd_way_group_i), .cmd_tag_i(cmd_tag_i),
    .ram_v_o(ram_v_o), .ram_addr_o(ram_addr_o), .ram_data_i(ram_data_i),
    .sharers_v_o(sharers_v_o), .sharers_yumi_i(sharers_yumi_i),
    .sharers_hits_o(sharers_hits_o), .sharers_ways_o(sharers_ways_o),
    .sharers_coh_states_o(sharers_coh_states_o), .multihit_o(multihit_o)
  );

  always #5 clk_i = ~clk_i;

  // Directory RAM model: one-cycle read latency.
  always @(posedge clk_i) ram_data_i <= ram_v_o ? dir_mem[ram_addr_o] : '0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic set_entry(input logic [5:0] wg, input int lce, input int way,
                           input logic [2:0] st, input logic [19:0] tg);
    logic [7:0] a;
    a = {wg, 2'(lce * 2 + way / 4)};
    dir_mem[a][(way % 4) * 23 +: 23] = {st, tg};
  endtask

  // Issues one lookup and checks address sequence, latency and the final vectors; leaves the block in DONE.
  task automatic run_lookup(input string name, input logic [5:0] wg, input logic [19:0] tg,
                            input logic [1:0] e_hits, input logic [5:0] e_ways, input logic [5:0] e_states);
    @(negedge clk_i);
    checks++; if (cmd_ready_o !== 1'b1) begin failures++; $display("FAIL %s ready: got %b want 1", name, cmd_ready_o); end
    cmd_v_i = 1'b1; cmd_way_group_i = wg; cmd_tag_i = tg;
    @(negedge clk_i);
    cmd_v_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (ram_v_o !== 1'b1 || ram_addr_o !== {wg, 2'(k)}) begin
        failures++; $display("FAIL %s read%0d: got v=%b addr=%h want v=1 addr=%h", name, k, ram_v_o, ram_addr_o, {wg, 2'(k)});
      end
      checks++; if (sharers_v_o !== 1'b0) begin failures++; $display("FAIL %s early_v%0d: got %b want 0", name, k, sharers_v_o); end
      @(negedge clk_i);
    end
    checks++; if (ram_v_o !== 1'b0 || sharers_v_o !== 1'b0) begin
      failures++; $display("FAIL %s drain: got ram_v=%b sv=%b want 0 0", name, ram_v_o, sharers_v_o);
    end
    @(negedge clk_i);
    checks++; if (sharers_v_o !== 1'b1) begin failures++; $display("FAIL %s sharers_v: got %b want 1", name, sharers_v_o); end
    checks++; if (sharers_hits_o !== e_hits || sharers_ways_o !== e_ways || sharers_coh_states_o !== e_states) begin
      failures++; $display("FAIL %s vectors: got hits=%b ways=%h states=%h want hits=%b ways=%h states=%h",
                           name, sharers_hits_o, sharers_ways_o, sharers_coh_states_o, e_hits, e_ways, e_states);
    end
  endtask

  task automatic release_vectors(input string name);
    sharers_yumi_i = 1'b1;
    @(negedge clk_i);
    sharers_yumi_i = 1'b0;
    checks++; if (cmd_ready_o !== 1'b1 || sharers_v_o !== 1'b0) begin
      failures++; $display("FAIL %s yumi: got ready=%b sv=%b want 1 0", name, cmd_ready_o, sharers_v_o);
    end
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      checks++; if ({cmd_ready_o, ram_v_o, sharers_v_o, multihit_o} !== 4'b0 ||
                    {sharers_hits_o, sharers_ways_o, sharers_coh_states_o} !== 14'b0) begin
        failures++; $display("FAIL reset_outputs: got rdy=%b rv=%b sv=%b mh=%b h=%b w=%h s=%h want all 0",
                             cmd_ready_o, ram_v_o, sharers_v_o, multihit_o, sharers_hits_o, sharers_ways_o, sharers_coh_states_o);
      end
    end
    reset_n_i = 1'b1;
    #1;
    checks++; if (cmd_ready_o !== 1'b1) begin failures++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready_o); end
  endtask

  task automatic test_single_hit();
    set_entry(6'd5, 1, 6, coh_m, 20'h01234);
    set_entry(6'd5, 0, 1, coh_m, 20'h01235);
    run_lookup("single_hit", 6'd5, 20'h01234, 2'b10, 6'o60, 6'o60);
    release_vectors("single_hit");
  endtask

  task automatic test_hold_and_ignore();
    set_entry(6'd9, 0, 2, coh_s, 20'hABCDE);
    set_entry(6'd9, 1, 0, coh_s, 20'hABCDE);
    run_lookup("hold", 6'd9, 20'hABCDE, 2'b11, 6'o02, 6'o11);
    cmd_v_i = 1'b1;
    repeat (5) begin
      @(negedge clk_i);
      checks++; if (sharers_v_o !== 1'b1 || sharers_hits_o !== 2'b11 || sharers_ways_o !== 6'o02 ||
                    sharers_coh_states_o !== 6'o11 || cmd_ready_o !== 1'b0 || ram_v_o !== 1'b0) begin
        failures++; $display("FAIL hold_stable: got sv=%b h=%b w=%h s=%h rdy=%b rv=%b want 1 11 02 09 0 0",
                             sharers_v_o, sharers_hits_o, sharers_ways_o, sharers_coh_states_o, cmd_ready_o, ram_v_o);
      end
    end
    cmd_v_i = 1'b0;
    release_vectors("hold");
  endtask

  task automatic test_invalid_match();
    set_entry(6'h3F, 0, 3, coh_i, 20'h0F00D);
    set_entry(6'h3F, 1, 7, coh_e, 20'h0F00D);
    run_lookup("invalid_match", 6'h3F, 20'h0F00D, 2'b10, 6'o70, 6'o20);
    release_vectors("invalid_match");
  endtask

  task automatic test_miss_everywhere();
    run_lookup("miss", 6'd33, 20'h00000, 2'b00, 6'o00, 6'o00);
    release_vectors("miss");
  endtask

  task automatic test_multihit();
    set_entry(6'd12, 0, 1, coh_e, 20'h55555);
    set_entry(6'd12, 0, 5, coh_s, 20'h55555);
    run_lookup("multihit", 6'd12, 20'h55555, 2'b01, 6'o01, 6'o02);
    checks++; if (multihit_o !== exp_multihit) begin failures++; $display("FAIL multihit_flag: got %b want %b", multihit_o, exp_multihit); end
    release_vectors("multihit");
    run_lookup("sticky", 6'd5, 20'h01234, 2'b10, 6'o60, 6'o60);
    checks++; if (multihit_o !== exp_multihit) begin failures++; $display("FAIL multihit_sticky: got %b want %b", multihit_o, exp_multihit); end
    release_vectors("sticky");
  endtask

  task automatic test_reset_mid_lookup();
    logic bad;
    @(negedge clk_i);
    cmd_v_i = 1'b1; cmd_way_group_i = 6'd9; cmd_tag_i = 20'hABCDE;
    @(negedge clk_i);
    cmd_v_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b0;
    @(negedge clk_i);
    reset_n_i = 1'b1;
    #1;
    checks++; if (cmd_ready_o !== 1'b1 || ram_v_o !== 1'b0 || sharers_v_o !== 1'b0 || sharers_hits_o !== 2'b00 || multihit_o !== 1'b0) begin
      failures++; $display("FAIL reset_mid_state: got rdy=%b rv=%b sv=%b h=%b mh=%b want 1 0 0 00 0",
                           cmd_ready_o, ram_v_o, sharers_v_o, sharers_hits_o, multihit_o);
    end
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk_i);
      if (sharers_v_o !== 1'b0 || ram_v_o !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL reset_mid_quiet: got activity=%b want 0", bad); end
    run_lookup("after_reset", 6'd5, 20'h01234, 2'b10, 6'o60, 6'o60);
    release_vectors("after_reset");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) dir_mem[i] = '0;
    test_reset();
    test_single_hit();
    test_hold_and_ignore();
    test_invalid_match();
    test_miss_everywhere();
    test_multihit();
    test_reset_mid_lookup();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
